// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3/opcode encodings and the data-memory responder state type
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane enables, store data replication, load extraction/extension, misalign flag
module dmem_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sh = i_rword >> {i_addr, 3'b000};
    assign w_half_sh = i_rword >> {i_addr[1], 4'b0000};
    assign w_byte    = w_byte_sh[7:0];
    assign w_half    = w_half_sh[15:0];

    // Store data is replicated across lanes so the enables alone pick the target bytes
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'd0;
        o_rdata    = 32'd0;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_BU) ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            F3_H, F3_HU: begin
                o_misalign = i_addr[0];
                o_be       = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = (i_funct3 == F3_HU) ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            F3_W: begin
                o_misalign = (i_addr != 2'b00);
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rword;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder over a word array with programmable wait latency
// Optional: define DMEM_ZERO_WAIT_EN to ignore LATENCY and respond the cycle after accept.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_re,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

`ifdef DMEM_ZERO_WAIT_EN
    localparam int LAT_EFF = 0;
`else
    localparam int LAT_EFF = LATENCY;
`endif
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LAT_EFF < 2) ? 1 : $clog2(LAT_EFF + 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(LAT_EFF - 1);

    dmem_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic          r_resp_err;
    logic [31:0]   r_pend_rdata;
    logic          r_pend_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_ext;
    logic          w_misalign;
    logic          w_oor;
    logic          w_bad_f3;
    logic          w_err;
    logic          w_accept;
    logic [31:0]   w_ld_data;

    assign w_idx    = req_addr[AW+1:2];
    assign w_rword  = r_mem[w_idx];
    assign w_oor    = (req_addr >> (AW + 2)) != 32'd0;
    assign w_bad_f3 = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                    || (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU));
    assign w_err    = w_oor || w_misalign || (req_we == req_re) || w_bad_f3;
    assign w_accept = !rst && (r_state == IDLE) && req_valid;
    assign w_ld_data = (w_err || req_we) ? 32'd0 : w_ext;

    dmem_align u_align (
        .i_funct3   (req_funct3),
        .i_addr     (req_addr[1:0]),
        .i_wdata    (req_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_ext),
        .o_misalign (w_misalign)
    );

    // Stores commit at the accept edge; the array is never cleared by reset
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_pend_rdata <= 32'd0;
            r_pend_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_pend_rdata <= w_ld_data;
                        r_pend_err   <= w_err;
                        r_req_ready  <= 1'b0;
                        if (LAT_EFF == 0) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_ld_data;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_state      <= RESP;
                        r_cnt        <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_pend_rdata;
                        r_resp_err   <= r_pend_err;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed plus randomized checks of dmem_responder against a byte-array model
module tb_dmem_responder;

    localparam int DEPTH = 256;
`ifdef DMEM_ZERO_WAIT_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_re = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [DEPTH*4];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_re     (req_re),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with access rules stated in plain arithmetic
    task automatic model(input logic we, input logic re, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        int size;
        logic uns;
        logic ok_f3;
        longint val;
        ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        uns   = f3[2];
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err   = (addr >= DEPTH*4) || ((addr % size) != 0) || (we == re) || !ok_f3 || (uns && we);
        rd    = 32'd0;
        if (!err && we) begin
            for (int i = 0; i < size; i++) mem_m[addr + i] = wdata[8*i +: 8];
        end
        if (!err && re) begin
            val = 0;
            for (int i = 0; i < size; i++) val = val + (longint'(mem_m[addr + i]) << (8*i));
            if (!uns && size < 4 && val >= (longint'(1) << (8*size - 1))) val = val - (longint'(1) << (8*size));
            rd = val[31:0];
        end
    endtask

    task automatic txn(input logic we, input logic re, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] got_rd, output logic got_err);
        int n;
        logic [31:0] exp_rd;
        logic exp_err;
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_re = re; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_re = $urandom; req_addr = $urandom;
        model(we, re, f3, addr, wdata, exp_rd, exp_err);
        n = 0;
        while (!resp_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("resp_latency", n, EXP_LAT);
        got_rd = resp_rdata;
        got_err = resp_err;
        check($sformatf("rdata@%h_f3%0d", addr, f3), resp_rdata, exp_rd);
        check($sformatf("err@%h_f3%0d", addr, f3), {31'd0, resp_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] a;
        int seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) txn(1, 0, 3'd2, 32'(w*4), $urandom, rd, er);

        txn(1, 0, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
        txn(0, 1, 3'd2, 32'h10, 32'h0, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);

        txn(1, 0, 3'd2, 32'h20, 32'h11223344, rd, er);
        txn(1, 0, 3'd0, 32'h21, 32'h000000AA, rd, er);
        txn(0, 1, 3'd2, 32'h20, 32'h0, rd, er);
        check("lw_20_after_sb", rd, 32'h1122AA44);
        txn(0, 1, 3'd0, 32'h21, 32'h0, rd, er);
        check("lb_21", rd, 32'hFFFFFFAA);
        txn(0, 1, 3'd4, 32'h21, 32'h0, rd, er);
        check("lbu_21", rd, 32'h000000AA);

        txn(1, 0, 3'd1, 32'h32, 32'h00008001, rd, er);
        txn(0, 1, 3'd1, 32'h32, 32'h0, rd, er);
        check("lh_32", rd, 32'hFFFF8001);
        txn(0, 1, 3'd5, 32'h32, 32'h0, rd, er);
        check("lhu_32", rd, 32'h00008001);

        txn(0, 1, 3'd2, 32'h13, 32'h0, rd, er);
        check("lw_13_err", {31'd0, er}, 32'd1);
        txn(0, 1, 3'd1, 32'h31, 32'h0, rd, er);
        check("lh_31_err", {31'd0, er}, 32'd1);
        txn(1, 0, 3'd2, 32'h400, 32'h55555555, rd, er);
        check("sw_400_err", {31'd0, er}, 32'd1);
        txn(1, 1, 3'd2, 32'h10, 32'h12345678, rd, er);
        check("we_re_err", {31'd0, er}, 32'd1);
        txn(1, 0, 3'd4, 32'h10, 32'h12345678, rd, er);
        txn(0, 1, 3'd2, 32'h10, 32'h0, rd, er);
        check("lw_10_unchanged", rd, 32'hDEADBEEF);

`ifndef DMEM_ZERO_WAIT_EN
        txn(1, 0, 3'd2, 32'h40, 32'hCAFEF00D, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 0; req_re = 1; req_funct3 = 3'd2; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        repeat (5) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_wait_no_resp", seen, 0);
        txn(0, 1, 3'd2, 32'h40, 32'h0, rd, er);
        check("sw_persists_rst", rd, 32'hCAFEF00D);
`else
        @(negedge clk);
        req_valid = 1'b1; req_we = 0; req_re = 1; req_funct3 = 3'd2; req_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("zw_ready_c%0d", c), {31'd0, req_ready}, {31'd0, c[0]});
            check($sformatf("zw_valid_c%0d", c), {31'd0, resp_valid}, {31'd0, ~c[0]});
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
`endif

        for (int t = 0; t < 250; t++) begin
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 - 1));
            case ($urandom_range(0, 9))
                0:       txn(1, 1, 3'($urandom), a, $urandom, rd, er);
                1:       txn(0, 0, 3'($urandom), a, $urandom, rd, er);
                2, 3, 4: txn(1, 0, 3'($urandom), a, $urandom, rd, er);
                default: txn(0, 1, 3'($urandom), a, $urandom, rd, er);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
